ws2812_strip_driver: RTL and testbench



---
 rtl/ws2812_pkg.sv | 30 +++
 rtl/ws2812_strip_driver_bit_encoder.sv | 46 ++++
 rtl/ws2812_strip_driver.sv | 155 +++++++++++++++
 tb/tb_ws2812_strip_driver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types, FSM encoding and default 50 MHz timing for the WS2812 strip driver.
// The channel scaling helper is only referenced when WS2812_BRIGHTNESS_EN is defined.
package ws2812_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    LATCH
  } state_t;

  localparam int DEF_BIT_CYC   = 63;
  localparam int DEF_T0H_CYC   = 20;
  localparam int DEF_T1H_CYC   = 40;
  localparam int DEF_LATCH_CYC = 2600;

  // c * (b + 1) never exceeds 255 * 256, so the product fits in 16 bits.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return 8'(prod >> 8);
  endfunction

  function automatic pixel_t scale_pixel(input pixel_t p, input logic [7:0] b);
    return {scale_chan(p[23:16], b), scale_chan(p[15:8], b), scale_chan(p[7:0], b)};
  endfunction

endpackage

// File: rtl/ws2812_strip_driver_bit_encoder.sv
// Produces one WS2812 bit waveform per BIT_CYC-cycle period for as long as go is held.
// bit_last marks the final cycle of each period so the caller can advance to the next bit.
module ws2812_bit_encoder #(
  parameter int BIT_CYC = 63,
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic bit_last
);

  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H  = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H  = CW'(T1H_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;

  always_comb begin
    cnt_d  = '0;
    dout_d = 1'b0;
    if (go) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      dout_d = cnt_q < (bit_val ? T1H : T0H);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign bit_last = go && (cnt_q == LAST);

endmodule

// File: rtl/ws2812_strip_driver.sv
// WS2812 strip driver: pixel buffer, frame FSM and GRB shift register feeding the bit encoder.
// Define WS2812_BRIGHTNESS_EN to scale every channel by (brightness+1)/256 at pixel load.
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = 60,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int LATCH_CYC = DEF_LATCH_CYC,
  parameter int ADDR_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic [7:0]        brightness,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              dout
);

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
    $error("ws2812_strip_driver: timing must satisfy 0 < T0H_CYC < T1H_CYC < BIT_CYC");
  end
  if (NUM_LEDS < 1 || LATCH_CYC < 1) begin : g_bad_size
    $error("ws2812_strip_driver: NUM_LEDS and LATCH_CYC must be at least 1");
  end

  localparam int LW = $clog2(LATCH_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LW-1:0]     LATCH_LAST = LW'(LATCH_CYC - 1);

  pixel_t mem [NUM_LEDS];
  pixel_t rd_data_q;
  pixel_t load_data;
  logic [ADDR_W-1:0] rd_addr;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  pixel_t            shift_q, shift_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [LW-1:0]     latch_cnt_q, latch_cnt_d;
  logic              bit_last;

  // The read port tracks the next pixel every cycle, so late writes still land if not yet loaded.
  assign rd_addr = (state_q == SEND && pix_q != LAST_PIX) ? pix_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (wr_en && int'(wr_addr) < NUM_LEDS) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

`ifdef WS2812_BRIGHTNESS_EN
  assign load_data = scale_pixel(rd_data_q, brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign load_data = rd_data_q;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    pix_d       = pix_q;
    latch_cnt_d = latch_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d   = FETCH;
          busy_d    = 1'b1;
          pix_d     = '0;
          bit_idx_d = '0;
        end
      end
      FETCH: begin
        shift_d = load_data;
        state_d = SEND;
      end
      SEND: begin
        if (bit_last) begin
          if (bit_idx_q == 5'd23) begin
            bit_idx_d = '0;
            if (pix_q == LAST_PIX) begin
              state_d     = LATCH;
              latch_cnt_d = '0;
            end else begin
              pix_d   = pix_q + 1'b1;
              shift_d = load_data;
            end
          end else begin
            bit_idx_d = bit_idx_q + 5'd1;
            shift_d   = {shift_q[22:0], 1'b0};
          end
        end
      end
      LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      pix_q       <= '0;
      latch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      pix_q       <= pix_d;
      latch_cnt_q <= latch_cnt_d;
    end
  end

  ws2812_bit_encoder #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC)
  ) u_enc (
    .clk      (clk),
    .rst      (rst),
    .go       (state_q == SEND),
    .bit_val  (shift_q[23]),
    .dout     (dout),
    .bit_last (bit_last)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed bench for a two-pixel strip with short timing; each frame's dout waveform is decoded back
// into 48 bits and compared against hand-computed GRB values, along with busy/done timing.
module tb_ws2812_strip_driver;

  localparam int NUM_LEDS = 2;
  localparam int BIT_CYC  = 10;
  localparam int T0H      = 3;
  localparam int T1H      = 6;
  localparam int LATCH    = 20;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        wr_en      = 1'b0;
  logic [1:0]  wr_addr    = '0;
  logic [23:0] wr_data    = '0;
  logic [7:0]  brightness = 8'd255;
  logic        start      = 1'b0;
  logic        busy;
  logic        done;
  logic        dout;

  int errors = 0;
  int checks = 0;

  ws2812_strip_driver #(
    .NUM_LEDS  (NUM_LEDS),
    .BIT_CYC   (BIT_CYC),
    .T0H_CYC   (T0H),
    .T1H_CYC   (T1H),
    .LATCH_CYC (LATCH),
    .ADDR_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .brightness (brightness),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [23:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  // Edge n counts from the edge that samples start (n=0); bit k occupies edges 2+10k .. 11+10k.
  task automatic runFrame(input string tag, input bit hold_start, input int wr_edge,
                          input logic [1:0] w_addr, input logic [23:0] w_data,
                          input logic [47:0] exp_bits);
    logic [47:0] bits;
    logic [9:0]  pat;
    int bad_bits, done_edge, latch_high, busy_gaps;
    bits = '0; pat = '0; bad_bits = 0; done_edge = -1; latch_high = 0; busy_gaps = 0;
    start = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_busy_rise"}, 64'(busy), 64'd1);
    if (!hold_start) start = 1'b0;
    for (int n = 1; n <= 600 && done_edge < 0; n++) begin
      if (n == wr_edge) begin
        wr_en   = 1'b1;
        wr_addr = w_addr;
        wr_data = w_data;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (n == 1) begin
        if (dout) bad_bits++;
      end else if (n <= 481) begin
        pat[9 - ((n - 2) % 10)] = dout;
        if ((n - 2) % 10 == 9) begin
          if (pat == 10'b1111110000)      bits[47 - (n - 2) / 10] = 1'b1;
          else if (pat == 10'b1110000000) bits[47 - (n - 2) / 10] = 1'b0;
          else                            bad_bits++;
        end
      end else begin
        latch_high += int'(dout);
      end
      if (done) done_edge = n;
      else if (!busy) busy_gaps++;
    end
    checkOutput({tag, "_bits"}, 64'(bits), 64'(exp_bits));
    checkOutput({tag, "_bit_shape"}, 64'(bad_bits), 64'd0);
    checkOutput({tag, "_done_cycle"}, 64'(done_edge), 64'd501);
    checkOutput({tag, "_latch_low"}, 64'(latch_high), 64'd0);
    checkOutput({tag, "_busy_held"}, 64'(busy_gaps), 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_idle_after"}, 64'(busy), 64'd0);
    start = 1'b0;
    if (hold_start) begin
      @(posedge clk); #1;
      checkOutput({tag, "_no_retrigger"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_dout", 64'(dout), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(2'd0, 24'hFF0000);
    applyStimulus(2'd1, 24'h000001);
    applyStimulus(2'd2, 24'hFFFFFF);
    applyStimulus(2'd3, 24'hABCDEF);
    runFrame("frame1", 1'b0, 0, 2'd0, 24'h0, {24'hFF0000, 24'h000001});

    runFrame("held", 1'b1, 0, 2'd0, 24'h0, {24'hFF0000, 24'h000001});

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (292) @(posedge clk);
    #1;
    checkOutput("pre_reset_high", 64'(dout), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_dout", 64'(dout), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    runFrame("replay", 1'b0, 0, 2'd0, 24'h0, {24'hFF0000, 24'h000001});

    runFrame("live_wr", 1'b0, 100, 2'd1, 24'h00FF00, {24'hFF0000, 24'h00FF00});
    runFrame("late_wr", 1'b0, 300, 2'd0, 24'h123456, {24'hFF0000, 24'h00FF00});
    runFrame("next_frame", 1'b0, 0, 2'd0, 24'h0, {24'h123456, 24'h00FF00});

    brightness = 8'd127;
    applyStimulus(2'd0, 24'hFF8001);
`ifdef WS2812_BRIGHTNESS_EN
    runFrame("bright", 1'b0, 0, 2'd0, 24'h0, {24'h7F4000, 24'h007F00});
`else
    runFrame("bright", 1'b0, 0, 2'd0, 24'h0, {24'hFF8001, 24'h00FF00});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
